// File: rtl/bp_update_sched.sv
// Branch-predictor table scheduler: mispredict flush/redirect, 4-deep training-write
// FIFO, single-port arbitration between fetch lookups and training writes, post-reset table clear.
module bp_update_sched #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          res_valid,
  input  logic [11:0]   res_pc,
  input  logic [11:0]   res_target,
  input  logic          res_taken,
  input  logic          res_pred_taken,
  input  logic [11:0]   res_pred_target,
  input  logic [1:0]    res_ctr,
  input  logic          lookup_req,
  output logic          lookup_gnt,
  output logic          flush,
  output logic [11:0]   redirect_pc,
  output logic          stall_req,
  output logic          init_busy,
  output logic          tbl_we,
  output logic [N-1:0]  tbl_idx,
  output logic [9-N:0]  tbl_tag,
  output logic [11:0]   tbl_target,
  output logic [1:0]    tbl_ctr,
  output logic          tbl_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [N-1:0] idx;
    logic [9-N:0] tag;
    logic [11:0]  target;
    logic [1:0]   ctr;
  } upd_t;

  // Saturating 2-bit counter training toward the resolved outcome.
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'd3) nxt = ctr + 2'd1;
      else             nxt = ctr;
    end else begin
      if (ctr != 2'd0) nxt = ctr - 2'd1;
      else             nxt = ctr;
    end
    return nxt;
  endfunction

  state_t          state_r;
  logic [N-1:0]    init_idx_r;
  upd_t            fifo_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [1:0]      age_r;

  logic            mis_s;
  logic [11:0]     redirect_s;
  logic            fifo_ne_s;
  logic            fifo_full_s;
  logic            push_s;
  logic            pop_s;
  upd_t            push_entry_s;
  upd_t            head_s;
  logic [CW-1:0]   count_next_s;
  logic [1:0]      age_next_s;

  assign head_s = fifo_mem_r[rd_ptr_r];

  // Mispredict detection, FIFO push/pop decision and next-count/age.
  always_comb begin
    mis_s       = res_valid & ((res_taken != res_pred_taken) |
                               (res_taken & (res_pred_target != res_target)));
    redirect_s  = res_taken ? res_target : (res_pc + 12'd4);
    fifo_ne_s   = (count_r != {CW{1'b0}});
    fifo_full_s = (count_r == FULL_CNT);

    push_entry_s.idx    = res_pc[N+1:2];
    push_entry_s.tag    = res_pc[11:N+2];
    push_entry_s.target = res_target;
    push_entry_s.ctr    = ctr_train(res_ctr, res_taken);

    // Full or aged-out head takes the port even against a pending lookup.
    if (state_r == RUN) begin
      push_s = res_valid;
      pop_s  = fifo_ne_s & (~lookup_req | fifo_full_s | (age_r == 2'd3));
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase

    if (pop_s) begin
      age_next_s = 2'd0;
    end else if (fifo_ne_s & lookup_req & (age_r != 2'd3)) begin
      age_next_s = age_r + 2'd1;
    end else if (fifo_ne_s) begin
      age_next_s = age_r;
    end else begin
      age_next_s = 2'd0;
    end
  end

  // FIFO storage; pointers and count live in the control block below.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // Control FSM with registered table-port, flush and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= INIT;
      init_idx_r  <= {N{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      age_r       <= 2'd0;
      lookup_gnt  <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= 12'd0;
      stall_req   <= 1'b0;
      init_busy   <= 1'b0;
      tbl_we      <= 1'b0;
      tbl_idx     <= {N{1'b0}};
      tbl_tag     <= {(10-N){1'b0}};
      tbl_target  <= 12'd0;
      tbl_ctr     <= 2'b00;
      tbl_vld     <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          lookup_gnt  <= 1'b0;
          flush       <= 1'b0;
          redirect_pc <= 12'd0;
          stall_req   <= 1'b0;
          init_busy   <= 1'b1;
          tbl_we      <= 1'b1;
          tbl_idx     <= init_idx_r;
          tbl_tag     <= {(10-N){1'b0}};
          tbl_target  <= 12'd0;
          tbl_ctr     <= 2'b01;
          tbl_vld     <= 1'b0;
          init_idx_r  <= init_idx_r + N'(1);
          if (init_idx_r == {N{1'b1}}) state_r <= RUN;
          else                         state_r <= INIT;
        end
        RUN: begin
          init_busy   <= 1'b0;
          flush       <= mis_s;
          redirect_pc <= mis_s ? redirect_s : 12'd0;
          if (pop_s) begin
            lookup_gnt <= 1'b0;
            tbl_we     <= 1'b1;
            tbl_vld    <= 1'b1;
            tbl_idx    <= head_s.idx;
            tbl_tag    <= head_s.tag;
            tbl_target <= head_s.target;
            tbl_ctr    <= head_s.ctr;
            rd_ptr_r   <= rd_ptr_r + AW'(1);
          end else begin
            lookup_gnt <= lookup_req;
            tbl_we     <= 1'b0;
            tbl_vld    <= 1'b0;
            tbl_idx    <= {N{1'b0}};
            tbl_tag    <= {(10-N){1'b0}};
            tbl_target <= 12'd0;
            tbl_ctr    <= 2'b00;
          end
          if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
          count_r   <= count_next_s;
          age_r     <= age_next_s;
          stall_req <= (count_next_s >= STALL_CNT);
        end
        default: begin
          state_r <= INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Scheduler for the branch-predictor table (tag / 2-bit BHT counter / BTB target per entry, one shared single-port array). It sits between the EX-stage branch resolution logic and the predictor table. It detects mispredictions and issues a one-cycle flush/redirect to fetch. It queues table-training writes in a 4-entry FIFO and arbitrates the single table port between fetch lookups and those writes. After reset it sequences a full-table clear before any lookup is granted.

## Interface
- N, 8, index width; table has 2^N entries, tag width 10-N, index = PC[N+1:2], tag = PC[11:N+2]
- DEPTH, 4, update FIFO depth (power of two)
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- res_valid  in  1  resolved branch/jump in EX this cycle
- res_pc  in  12  PC of resolved instruction
- res_target  in  12  ALU-computed target (valid regardless of outcome)
- res_taken  in  1  actual outcome
- res_pred_taken  in  1  prediction made at fetch
- res_pred_target  in  12  predicted target used at fetch
- res_ctr  in  2  BHT counter read at fetch for this instruction
- lookup_req  in  1  fetch requests table port this cycle
- lookup_gnt  out  1  fetch owns table port this cycle
- flush  out  1  one-cycle pipeline flush
- redirect_pc  out  12  fetch PC when flush=1
- stall_req  out  1  EX must not present a new res_valid next cycle
- init_busy  out  1  table clear in progress
- tbl_we, tbl_idx[N-1:0], tbl_tag[9-N:0], tbl_target[11:0], tbl_ctr[1:0], tbl_vld  out  table write port

## Operation
- FSM states: INIT, RUN. RST → INIT, idx counter=0, FIFO emptied, all outputs 0.
- INIT: each cycle tbl_we=1, tbl_idx=counter, tbl_vld=0, tbl_ctr=2'b01, tbl_tag=0, tbl_target=0; counter++. After writing index 2^N−1 → RUN. init_busy=1, lookup_gnt=0 throughout; res_valid ignored.
- Mispredict: mis = res_valid & (res_taken≠res_pred_taken | (res_taken & res_pred_target≠res_target)).
- On mis, next cycle: flush=1, redirect_pc = res_taken ? res_target : res_pc+4, with 12-bit wrap (0xFFC+4=0x000).
- Every res_valid in RUN pushes {idx, tag, res_target, ctr'} where ctr' = res_taken ? min(res_ctr+1,3) : max(res_ctr−1,0). A correct prediction is also pushed.
- Arbitration in RUN, one port use per cycle:
  - update wins if FIFO non-empty and (!lookup_req | FIFO full | age≥3);
  - otherwise lookup_gnt=lookup_req.
  - age counts consecutive cycles the FIFO head has been denied. It resets to 0 on a pop and saturates at 3.
- A pop drives tbl_we=1, tbl_vld=1, and the head fields.
- stall_req = registered (count ≥ DEPTH−1). A push with the FIFO full and no same-cycle pop is impossible, because full forces a pop. A simultaneous push and pop leaves count unchanged.
- Reset mid-INIT or mid-RUN: clear restarts at index 0 and queued updates are discarded.

## Timing
- INIT lasts exactly 2^N cycles after the first cycle with RST=0. lookup_gnt can first assert on cycle 2^N+1.
- flush/redirect_pc: registered, 1 cycle after res_valid, high for exactly 1 cycle. Back-to-back mispredicts give back-to-back flush pulses.
- A pushed entry can pop at the earliest on the cycle after the push; FIFO is not bypassed.
- stall_req reflects count at the previous cycle's end (1-cycle latency).
- Lookup starvation bound: no FIFO entry waits more than 3 cycles once at head.

## Test plan
- Reset/INIT, N=8:
  - release RST → tbl_we=1 for 256 cycles, tbl_idx 0..255, tbl_vld=0, tbl_ctr=01, init_busy=1;
  - then init_busy=0 and lookup_gnt follows lookup_req.
- Mispredict taken: res_pc=0x100, res_target=0x040, taken=1, pred_taken=0, ctr=01.
  - Next cycle flush=1, redirect_pc=0x040.
  - Later pop writes idx=0x40, tag=0, target=0x040, ctr=10.
- Mispredict not-taken wrap: res_pc=0xFFC, taken=0, pred_taken=1, ctr=00.
  - Expect redirect_pc=0x000 and written ctr=00 (saturation).
- Arbitration: lookup_req held 1 with one queued update.
  - Expect lookup_gnt for 3 cycles, then the pop on the 4th cycle with lookup_gnt=0.
- FIFO pressure: res_valid every cycle with lookup_req=1.
  - Expect stall_req=1 once count=3.
  - When full, pops every cycle; no entry lost (all 4 writes observed in order).
- Reset mid-RUN with 3 queued updates: assert RST for 1 cycle.
  - Expect no tbl_vld=1 write afterward until new pushes; INIT restarts at idx 0.
